// File: rtl/iomem_rgb_pwm_if.sv
// PicoSoC iomem bus bundle as seen by the RGB PWM controller.
interface iomem_rgb_pwm_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid,
    output iomem_wstrb,
    output iomem_addr,
    output iomem_wdata,
    input  iomem_ready,
    input  iomem_rdata
  );

  modport slave (
    input  iomem_valid,
    input  iomem_wstrb,
    input  iomem_addr,
    input  iomem_wdata,
    output iomem_ready,
    output iomem_rdata
  );
endinterface

// File: rtl/iomem_rgb_pwm.sv
// Memory-mapped RGB LED PWM controller on the PicoSoC iomem bus.
// 16-bit prescaler, 8-bit counter, duties double-buffered to the period boundary.
module iomem_rgb_pwm #(
  parameter logic [7:0] ADDR_HI = 8'h04
) (
  input  logic           clk,
  input  logic           resetn,
  iomem_rgb_pwm_if.slave bus,
  output logic           ledr_n,
  output logic           ledg_n,
  output logic           ledb_n
);

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, en_d;
  logic [15:0] presc_q, presc_d;
  logic [23:0] duty_q, duty_d;  // shadow {B, G, R}
  logic [23:0] act_q, act_d;    // active {B, G, R}
  logic [15:0] pre_q, pre_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wrap_q, wrap_d;
  logic [2:0]  led_q, led_d;    // {b, g, r}, active-low

  logic        sel;
  logic        wr;
  logic        tick;
  logic [31:0] rd_val;
  logic        addr_unused;

  assign addr_unused = ^{bus.iomem_addr[23:4], bus.iomem_addr[1:0]};

  always_comb begin
    sel = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == ADDR_HI);
    wr  = sel && (bus.iomem_wstrb != 4'b0000);

    case (bus.iomem_addr[3:2])
      2'd0:    rd_val = {presc_q, 15'b0, en_q};
      2'd1:    rd_val = {8'b0, duty_q};
      2'd2:    rd_val = {23'b0, wrap_q, cnt_q};
      default: rd_val = 32'b0;
    endcase

    ready_d = sel;
    rdata_d = sel ? rd_val : rdata_q;
    en_d    = en_q;
    presc_d = presc_q;
    duty_d  = duty_q;
    act_d   = act_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    led_d   = led_q;
    tick    = (pre_q == presc_q);

    if (wr) begin
      case (bus.iomem_addr[3:2])
        2'd0: begin
          if (bus.iomem_wstrb[0]) en_d = bus.iomem_wdata[0];
          if (bus.iomem_wstrb[2]) presc_d[7:0] = bus.iomem_wdata[23:16];
          if (bus.iomem_wstrb[3]) presc_d[15:8] = bus.iomem_wdata[31:24];
        end
        2'd1: begin
          if (bus.iomem_wstrb[0]) duty_d[7:0] = bus.iomem_wdata[7:0];
          if (bus.iomem_wstrb[1]) duty_d[15:8] = bus.iomem_wdata[15:8];
          if (bus.iomem_wstrb[2]) duty_d[23:16] = bus.iomem_wdata[23:16];
        end
        2'd2: begin
          if (bus.iomem_wstrb[1] && bus.iomem_wdata[8]) wrap_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Engine runs after the bus decode so a wrap in the same cycle beats a W1C clear.
    if (en_q) begin
      pre_d = tick ? 16'd0 : pre_q + 16'd1;
      if (tick) begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'hFF) begin
          act_d  = duty_q;
          wrap_d = 1'b1;
        end
      end
      led_d[0] = !(cnt_q < act_q[7:0]);
      led_d[1] = !(cnt_q < act_q[15:8]);
      led_d[2] = !(cnt_q < act_q[23:16]);
    end else begin
      pre_d = 16'd0;
      cnt_d = 8'd0;
      act_d = duty_q;
      led_d = 3'b111;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= 32'b0;
      en_q    <= 1'b0;
      presc_q <= 16'd0;
      duty_q  <= 24'd0;
      act_q   <= 24'd0;
      pre_q   <= 16'd0;
      cnt_q   <= 8'd0;
      wrap_q  <= 1'b0;
      led_q   <= 3'b111;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      presc_q <= presc_d;
      duty_q  <= duty_d;
      act_q   <= act_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      led_q   <= led_d;
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign ledr_n = led_q[0];
  assign ledg_n = led_q[1];
  assign ledb_n = led_q[2];

endmodule

// File: tb/tb_iomem_rgb_pwm.sv
// Self-checking bench for iomem_rgb_pwm: register model, timing-derived CNT/WRAP
// expectations and per-period LED low-cycle counts from duty arithmetic.
module tb_iomem_rgb_pwm;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic ledr_n, ledg_n, ledb_n;

  iomem_rgb_pwm_if bus ();

  iomem_rgb_pwm #(.ADDR_HI(8'h04)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .ledr_n (ledr_n),
    .ledg_n (ledg_n),
    .ledb_n (ledb_n)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;  // number of rising edges so far

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] last_rdata;
  int unsigned last_edge;

  // Per-period LED low counters; period 0 starts at mon_base.
  logic        mon_en = 1'b0;
  int unsigned mon_base = 0;
  int unsigned mon_len = 256;
  int unsigned low_cnt [3][4];
  int unsigned mon_idx;

  always @(negedge clk) begin
    if (!mon_en) begin
      for (int c = 0; c < 3; c++)
        for (int p = 0; p < 4; p++) low_cnt[c][p] = 0;
    end else if (cyc >= mon_base) begin
      mon_idx = (cyc - mon_base) / mon_len;
      if (mon_idx < 4) begin
        if (!ledr_n) low_cnt[0][mon_idx] = low_cnt[0][mon_idx] + 1;
        if (!ledg_n) low_cnt[1][mon_idx] = low_cnt[1][mon_idx] + 1;
        if (!ledb_n) low_cnt[2][mon_idx] = low_cnt[2][mon_idx] + 1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge two cycles later.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit hold);
    check("ready_idle", bus.iomem_ready, 1'b0);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wdata = wdata;
    bus.iomem_wstrb = wstrb;
    @(negedge clk);
    last_edge  = cyc;
    check("ready_ack", bus.iomem_ready, 1'b1);
    last_rdata = bus.iomem_rdata;
    if (!hold) begin
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'h0;
    end
    @(negedge clk);
    check("ready_drop", bus.iomem_ready, 1'b0);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
  endtask

  function automatic logic [31:0] reg_addr(input logic [1:0] r);
    return {8'h04, 20'h0, r, 2'b00};
  endfunction

  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
    access(reg_addr(r), d, s, 1'b0);
  endtask

  task automatic rd(input logic [1:0] r);
    access(reg_addr(r), 32'h0, 4'h0, 1'b0);
  endtask

  // Leave the negedge before edge `target`, so the next access lands on it.
  task automatic wait_edge(input int unsigned target);
    while (cyc + 1 < target) @(negedge clk);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s, input logic [31:0] mask);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r & mask;
  endfunction

  function automatic logic [31:0] stat_exp(input int unsigned k, input logic wrap,
                                           input int unsigned p);
    logic [7:0] c;
    c = 8'((k / (p + 1)) % 256);
    return {23'b0, wrap, c};
  endfunction

  // Enable with prescaler p and start the monitor on the first PWM-driven output cycle.
  task automatic enable_mon(input int unsigned p);
    mon_len  = 256 * (p + 1);
    mon_base = cyc + 2;
    mon_en   = 1'b1;
    wr(2'd0, {16'(p), 16'h0001}, 4'hF);
  endtask

  logic [31:0] m_ctrl, m_duty, m_exp;
  logic [1:0]  r_sel;
  logic [3:0]  r_strb;
  logic [31:0] r_data;
  logic [7:0]  dr, dg, db;
  int unsigned p, n, k, c_edge, t_edge;
  logic        wexp;

  initial begin
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wdata = 32'h0;

    // Reset state
    #2 resetn = 1'b0;
    #1;
    check("rst_ledr", ledr_n, 1'b1);
    check("rst_ledg", ledg_n, 1'b1);
    check("rst_ledb", ledb_n, 1'b1);
    check("rst_ready", bus.iomem_ready, 1'b0);
    check("rst_rdata", bus.iomem_rdata, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    rd(2'd0); check("rst_ctrl", last_rdata, 32'h0);
    rd(2'd1); check("rst_duty", last_rdata, 32'h0);
    rd(2'd2); check("rst_stat", last_rdata, 32'h0);

    // Byte strobes and ready held-valid behaviour
    wr(2'd0, 32'h0003_0001, 4'hF);
    rd(2'd0); check("strb_full", last_rdata, 32'h0003_0001);
    wr(2'd0, 32'hFFFF_FFFF, 4'h4); check("strb_prewr", last_rdata, 32'h0003_0001);
    access(reg_addr(2'd0), 32'h0, 4'h0, 1'b1); check("strb_lane2", last_rdata, 32'h00FF_0001);
    wr(2'd0, 32'h0, 4'hF);

    // Address mismatch
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0500_0000;
    bus.iomem_wdata = 32'hFFFF_FFFF;
    bus.iomem_wstrb = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("miss_ready", bus.iomem_ready, 1'b0);
    end
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    rd(2'd0); check("miss_ctrl", last_rdata, 32'h0);

    // Random register traffic against a byte-lane model
    m_ctrl = 32'h0;
    m_duty = 32'h0;
    for (int i = 0; i < 24; i++) begin
      k      = $urandom_range(0, 2);
      r_sel  = (k == 2) ? 2'd3 : 2'(k);
      r_strb = 4'($urandom_range(0, 15));
      r_data = $urandom;
      m_exp  = (r_sel == 2'd0) ? m_ctrl : (r_sel == 2'd1) ? m_duty : 32'h0;
      wr(r_sel, r_data, r_strb);
      check("rand_prewr", last_rdata, m_exp);
      if (r_sel == 2'd0) m_ctrl = merge(m_ctrl, r_data, r_strb, 32'hFFFF_0001);
      if (r_sel == 2'd1) m_duty = merge(m_duty, r_data, r_strb, 32'h00FF_FFFF);
      m_exp = (r_sel == 2'd0) ? m_ctrl : (r_sel == 2'd1) ? m_duty : 32'h0;
      rd(r_sel);
      check("rand_rdback", last_rdata, m_exp);
    end
    wr(2'd0, 32'h0, 4'hF);

    // Duty accuracy, fixed pattern
    wr(2'd1, 32'h00FF_8000, 4'hF);
    enable_mon(0);
    while (cyc < mon_base + mon_len) @(negedge clk);
    check("duty_r", low_cnt[0][0], 0);
    check("duty_g", low_cnt[1][0], 128);
    check("duty_b", low_cnt[2][0], 255);
    mon_en = 1'b0;
    wr(2'd0, 32'h0, 4'hF);

    // Duty accuracy, random duties and prescalers
    for (int i = 0; i < 3; i++) begin
      dr = 8'($urandom_range(0, 255));
      dg = (i == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      db = (i == 1) ? 8'h00 : 8'($urandom_range(0, 255));
      p  = $urandom_range(0, 2);
      wr(2'd1, {8'h0, db, dg, dr}, 4'h7);
      enable_mon(p);
      while (cyc < mon_base + 2 * mon_len) @(negedge clk);
      for (int q = 0; q < 2; q++) begin
        check("rduty_r", low_cnt[0][q], dr * (p + 1));
        check("rduty_g", low_cnt[1][q], dg * (p + 1));
        check("rduty_b", low_cnt[2][q], db * (p + 1));
      end
      mon_en = 1'b0;
      wr(2'd0, 32'h0, 4'hF);
    end

    // Shadow update lands at the next period boundary
    wr(2'd1, 32'h0000_1000, 4'hF);
    enable_mon(0);
    n = mon_base - 1;
    wait_edge(n + 256 + 65);
    wr(2'd1, 32'h0000_F000, 4'h2);
    while (cyc < mon_base + 3 * mon_len) @(negedge clk);
    check("shadow_p0", low_cnt[1][0], 16);
    check("shadow_p1", low_cnt[1][1], 16);
    check("shadow_p2", low_cnt[1][2], 240);
    mon_en = 1'b0;
    wr(2'd0, 32'h0, 4'hF);

    // Prescaler, CNT progression and sticky WRAP
    p = 3;
    wr(2'd2, 32'h0000_0100, 4'h2);
    rd(2'd2); check("wrap_clr0", last_rdata, 32'h0);
    wr(2'd0, 32'h0003_0001, 4'hF);
    n = last_edge;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(70, 150)) @(negedge clk);
      rd(2'd2);
      k = last_edge - 1 - n;
      check("stat_run", last_rdata, stat_exp(k, k >= 1024, p));
    end
    wr(2'd2, 32'h0000_0100, 4'h2);
    c_edge = last_edge;
    k = c_edge - 1 - n;
    check("w1c_prewr", last_rdata, stat_exp(k, 1'b1, p));
    rd(2'd2);
    k = last_edge - 1 - n;
    wexp = ((c_edge - n) % 1024 == 0) || ((k / 1024) > ((c_edge - n) / 1024));
    check("w1c_after", last_rdata, stat_exp(k, wexp, p));
    t_edge = n + 1024 * (((cyc + 4 - n) / 1024) + 1);
    wait_edge(t_edge);
    wr(2'd2, 32'h0000_0100, 4'h2);
    check("setwin_cnt", last_rdata[7:0], 8'hFF);
    rd(2'd2);
    check("setwin_wrap", last_rdata[8], 1'b1);
    wr(2'd0, 32'h0, 4'hF);

    // Disable mid-period
    wr(2'd1, 32'h00FF_FFFF, 4'hF);
    wr(2'd0, 32'h0000_0001, 4'hF);
    n = last_edge;
    while (cyc < n + 100) @(negedge clk);
    check("dis_on_r", ledr_n, 1'b0);
    check("dis_on_b", ledb_n, 1'b0);
    wr(2'd0, 32'h0, 4'hF);
    check("dis_ledr", ledr_n, 1'b1);
    check("dis_ledg", ledg_n, 1'b1);
    check("dis_ledb", ledb_n, 1'b1);
    rd(2'd2);
    check("dis_cnt", last_rdata[7:0], 8'h00);

    // Asynchronous reset mid-period
    wr(2'd1, 32'h0000_0080, 4'hF);
    wr(2'd0, 32'h0000_0001, 4'hF);
    n = last_edge;
    while (cyc < n + 10) @(negedge clk);
    check("rst_pre_r", ledr_n, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check("arst_ledr", ledr_n, 1'b1);
    check("arst_ledg", ledg_n, 1'b1);
    check("arst_ledb", ledb_n, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    rd(2'd0); check("arst_ctrl", last_rdata, 32'h0);
    rd(2'd1); check("arst_duty", last_rdata, 32'h0);
    repeat (20) @(negedge clk);
    rd(2'd2); check("arst_stat", last_rdata, 32'h0);
    check("arst_idle_r", ledr_n, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iomem_rgb_pwm.md
# iomem_rgb_pwm

Memory-mapped RGB LED PWM controller on the PicoSoC `iomem` bus, in the address window next to the board GPIO register. Firmware programs a prescaler and three 8-bit duty values. The block drives the board's active-low `ledr_n`/`ledg_n`/`ledb_n` pins with glitch-free PWM. Duty updates are double-buffered and take effect only at a PWM period boundary.

## Interface
- `ADDR_HI`, 8'h04: value of `iomem_addr[31:24]` that selects this block.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `resetn`  in  1: reset, asynchronous and active-low.
- `iomem_valid`  in  1: bus request.
- `iomem_ready`  out  1: one-cycle acknowledge pulse.
- `iomem_wstrb`  in  4: byte write strobes; 0 means a read.
- `iomem_addr`  in  32: byte address; bits [3:2] select the register.
- `iomem_wdata`  in  32: write data.
- `iomem_rdata`  out  32: read data, registered.
- `ledr_n`, `ledg_n`, `ledb_n`  out  1 each: PWM outputs, active-low, registered.

## Operation
Register map (offset = `iomem_addr[3:2]`):
- 0: CTRL.
  - [0] EN.
  - [15:1] read 0.
  - [31:16] PRESC, 16-bit.
  - Read/write.
- 1: DUTY shadow.
  - [7:0] R, [15:8] G, [23:16] B.
  - [31:24] read 0; writes to it are ignored.
- 2: STATUS.
  - [7:0] current PWM count CNT, read-only.
  - [8] WRAP, sticky; cleared by writing 1 with `wstrb[1]` set.
  - Other bits read 0.
- 3: reserved. Reads 0; writes are acked and ignored.

Bus behaviour:
- Select condition: `iomem_valid && !iomem_ready && iomem_addr[31:24]==ADDR_HI`.
- Every byte lane with its strobe set is written; the other lanes are unchanged.
- `iomem_rdata` returns the pre-write value of the addressed register.

PWM engine:
- PRE is a 16-bit prescaler counter. CNT is the 8-bit PWM counter.
- While EN=1:
  - If PRE==PRESC: PRE←0 and a tick occurs. Otherwise PRE←PRE+1.
  - On a tick: CNT←CNT+1 (mod 256).
- When CNT wraps 255→0:
  - The active duty registers are loaded from the DUTY shadow.
  - WRAP←1.
  - If a W1C write of WRAP lands in the same cycle, the set wins.
- Channel output: `led*_n ← !(CNT < active_duty)`.
  - Duty 0: always off (pin high).
  - Duty 255: on for 255 of every 256 counts.
- While EN=0:
  - PRE and CNT are held at 0.
  - Active duties continuously track the shadow.
  - All `led*_n` are 1.
- EN 0→1: counting starts from PRE=0, CNT=0, using the duties present at enable.
- Writing PRESC while enabled takes effect immediately.
  - If PRE is already above the new PRESC, PRE counts up to 65535, wraps to 0, then compares normally. There is no forced tick.

## Timing
- Reset (asynchronous assert, release synchronous to `clk` edges):
  - `iomem_ready`=0, `iomem_rdata`=0.
  - CTRL, DUTY shadow, active duties, PRE, CNT and WRAP all 0.
  - `ledr_n`=`ledg_n`=`ledb_n`=1.
- Bus latency:
  - `valid` plus address match in cycle N gives `ready`=1 and valid `rdata` in cycle N+1.
  - `ready` drops in N+2, even if `valid` is still high.
  - The register write is visible from cycle N+1.
  - A back-to-back request is accepted every 2 cycles.
- Address mismatch: `ready` stays 0 and no state changes.
- Prescaler: a tick every PRESC+1 cycles. PWM period = 256×(PRESC+1) cycles.
- Outputs: a `led*_n` change follows the corresponding CNT change by 1 cycle.
- Duty write: if written at any time inside period k, it is applied at the start of period k+1. The first affected output change appears in the cycle after the CNT 255→0 transition.
- Reset mid-period: outputs go high immediately and asynchronously, and all state clears. After release, nothing runs until EN is written.

## Test plan
- Reset and defaults:
  - Stimulus: assert `resetn`=0 mid-operation with EN=1, R=0x80.
  - Response: all `led*_n`=1 within the same cycle. After release, CTRL, DUTY and STATUS all read 0x00000000.
- Read/write and byte strobes:
  - Stimulus: write CTRL=0x0003_0001 with wstrb=4'hF, then write 0xFFFF_FFFF with wstrb=4'h4.
  - Response: readback 0x0003_0001, then 0x00FF_0001.
  - `ready` is exactly one cycle, one cycle after `valid`.
  - An access at 0x0500_0000 never asserts `ready`.
- Duty accuracy:
  - Stimulus: PRESC=0, DUTY=0x00FF_8000 (R=0x00, G=0x80, B=0xFF), EN=1.
  - Response over one 256-cycle period: `ledr_n` low 0 cycles, `ledg_n` low 128 cycles, `ledb_n` low 255 cycles.
- Shadow update:
  - Stimulus: PRESC=0, G=0x10. Write G=0xF0 when CNT=0x40.
  - Response: the current period still shows 16 low cycles; the next period shows 240.
- Prescaler and wrap flag:
  - Stimulus: PRESC=3.
  - Response: CNT advances every 4 cycles; WRAP sets after 1024 cycles.
  - Writing STATUS=0x100 clears WRAP.
  - A clear issued in the same cycle as a wrap leaves WRAP=1.
- Disable:
  - Stimulus: clear EN mid-period.
  - Response: outputs are 1 one cycle later, and CNT reads 0.
